plant_emulator: RTL and testbench



---
 rtl/plant_pkg.sv | 20 ++
 rtl/plant_delay_line.sv | 50 +++++
 rtl/plant_emulator.sv | 186 ++++++++++++++++++
 tb/tb_plant_emulator.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/plant_pkg.sv
// Shared definitions for the first-order-plus-dead-time plant model.
//   plant_state_t : sample-processing FSM states
//   ACC_W/FRAC_W  : lag accumulator width and fractional bits (8.8)
//   CLAMP_MIN/MAX : output saturation limits used when the load
//                   disturbance input is built in (PLANT_DISTURB_EN)
package plant_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FILTER  = 2'd2,
        ST_OUTPUT  = 2'd3
    } plant_state_t;

    localparam int ACC_W     = 16;
    localparam int FRAC_W    = 8;
    localparam int CLAMP_MIN = 0;
    localparam int CLAMP_MAX = 255;

endpackage

// File: rtl/plant_delay_line.sv
// Circular dead-time buffer for the plant model.
// Ports:
//   clk, rst   : clock and synchronous active-high reset (clears every entry)
//   wr_en      : write wr_data into entry wr_ptr at the end of this cycle
//   wr_ptr     : current write slot
//   wr_data    : sample being written
//   rd_offset  : how many samples back to read; 0 bypasses to wr_data
//   rd_data    : combinational read of entry (wr_ptr - rd_offset) mod DEPTH
module plant_delay_line
    import plant_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_ptr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [PTR_W-1:0]  rd_offset,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  rd_addr;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr] = wr_data;
        end
        // Pointer arithmetic wraps naturally because DEPTH is a power of two.
        rd_addr = wr_ptr - rd_offset;
        // Zero delay must return the sample being written this same cycle.
        rd_data = (rd_offset == '0) ? wr_data : mem_q[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/plant_emulator.sv
// First-order-plus-dead-time process model that closes the loop around
// the PID controller. Every sample period the control effort is pushed
// into a dead-time buffer, a delayed copy is pulled out and a first-order
// lag (tau ~ 2^lag_shift samples) is applied in 8.8 fixed point.
// Optional build macro: PLANT_DISTURB_EN adds a signed load disturbance
// that is added to the plant output with saturation to 0..255.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   ctrl_in      : control effort (controller control_out)
//   sample_div   : sample period minus one, in clk cycles
//   dead_time    : transport delay in samples (0..DELAY_DEPTH-1)
//   lag_shift    : lag time-constant exponent k
//   disturb      : signed load disturbance (PLANT_DISTURB_EN only)
//   feedback_out : plant output (controller feedback)
//   fb_valid     : one-cycle pulse when feedback_out updates
//   overrun      : sticky, a sample tick arrived while still processing
module plant_emulator
    import plant_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int DELAY_DEPTH = 16,
    parameter int DIV_W       = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_W-1:0]              ctrl_in,
    input  logic [DIV_W-1:0]               sample_div,
    input  logic [$clog2(DELAY_DEPTH)-1:0] dead_time,
    input  logic [2:0]                     lag_shift,
`ifdef PLANT_DISTURB_EN
    input  logic [DATA_W-1:0]              disturb,
`endif
    output logic [DATA_W-1:0]              feedback_out,
    output logic                           fb_valid,
    output logic                           overrun
);

    localparam int PTR_W = $clog2(DELAY_DEPTH);

    // One lag step: move acc toward the target by (target - acc) >>> k,
    // forcing at least +1 on the way up so the output lands exactly on
    // the target instead of stalling one LSB short. Going down, the
    // arithmetic shift already floors to -1, so it converges on its own.
    function automatic logic [ACC_W-1:0] lag_step(
        input logic [ACC_W-1:0]  acc,
        input logic [DATA_W-1:0] tgt,
        input logic [2:0]        k
    );
        logic signed [ACC_W:0] diff;
        logic signed [ACC_W:0] step;
        diff = $signed({1'b0, tgt, {FRAC_W{1'b0}}}) - $signed({1'b0, acc});
        step = diff >>> k;
        if (!diff[ACC_W] && (diff != '0) && (step == '0)) begin
            step = {{ACC_W{1'b0}}, 1'b1};
        end
        return acc + step[ACC_W-1:0];
    endfunction

`ifdef PLANT_DISTURB_EN
    // Unsigned plant output plus signed disturbance, evaluated two bits
    // wider than the data so neither overflow nor underflow wraps.
    function automatic logic [DATA_W-1:0] sat_out(
        input logic [DATA_W-1:0] base,
        input logic [DATA_W-1:0] dist
    );
        localparam logic signed [DATA_W+1:0] LO = (DATA_W+2)'(CLAMP_MIN);
        localparam logic signed [DATA_W+1:0] HI = (DATA_W+2)'(CLAMP_MAX);
        logic signed [DATA_W+1:0] sum;
        sum = $signed({2'b00, base}) + $signed({{2{dist[DATA_W-1]}}, dist});
        if (sum < LO) begin
            return LO[DATA_W-1:0];
        end else if (sum > HI) begin
            return HI[DATA_W-1:0];
        end
        return sum[DATA_W-1:0];
    endfunction
`endif

    plant_state_t      state_q, state_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0] delayed_q, delayed_d;
    logic [2:0]        k_q, k_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0] fb_q, fb_d;
    logic              fb_valid_q, fb_valid_d;
    logic              overrun_q, overrun_d;

    logic              tick;
    logic              wr_en;
    logic [DATA_W-1:0] rd_data;

    plant_delay_line #(
        .DATA_W (DATA_W),
        .DEPTH  (DELAY_DEPTH),
        .PTR_W  (PTR_W)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_ptr    (wr_ptr_q),
        .wr_data   (ctrl_in),
        .rd_offset (dead_time),
        .rd_data   (rd_data)
    );

    always_comb begin
        tick       = (div_cnt_q == sample_div);
        div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;

        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        delayed_d  = delayed_q;
        k_d        = k_q;
        acc_d      = acc_q;
        fb_d       = fb_q;
        fb_valid_d = 1'b0;
        overrun_d  = overrun_q;
        wr_en      = 1'b0;

        // Only IDLE can accept a sample; any other tick is lost.
        if (tick && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                wr_en     = 1'b1;
                delayed_d = rd_data;
                k_d       = lag_shift;
                state_d   = ST_FILTER;
            end
            ST_FILTER: begin
                acc_d   = lag_step(acc_q, delayed_q, k_q);
                state_d = ST_OUTPUT;
            end
            ST_OUTPUT: begin
`ifdef PLANT_DISTURB_EN
                fb_d = sat_out(acc_q[ACC_W-1:FRAC_W], disturb);
`else
                fb_d = acc_q[ACC_W-1:FRAC_W];
`endif
                fb_valid_d = 1'b1;
                wr_ptr_d   = wr_ptr_q + 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            div_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            delayed_q  <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            fb_q       <= '0;
            fb_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            delayed_q  <= delayed_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            fb_q       <= fb_d;
            fb_valid_q <= fb_valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign feedback_out = fb_q;
    assign fb_valid     = fb_valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_plant_emulator.sv
// Bench for plant_emulator: directed scenarios with literal expectations
// plus randomized runs, all compared every cycle against a time-based
// behavioural model of the plant.
module tb_plant_emulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  ctrl_in = '0;
    logic [15:0] sample_div = 16'd3;
    logic [3:0]  dead_time = '0;
    logic [2:0]  lag_shift = '0;
    logic [7:0]  disturb = '0;
    logic [7:0]  feedback_out;
    logic        fb_valid;
    logic        overrun;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    plant_emulator dut (
        .clk          (clk),
        .rst          (rst),
        .ctrl_in      (ctrl_in),
        .sample_div   (sample_div),
        .dead_time    (dead_time),
        .lag_shift    (lag_shift),
`ifdef PLANT_DISTURB_EN
        .disturb      (disturb),
`endif
        .feedback_out (feedback_out),
        .fb_valid     (fb_valid),
        .overrun      (overrun)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // cyc counts cycles since reset released; a tick occurs whenever
    // cyc mod (sample_div+1) == sample_div. An accepted tick at t samples
    // inputs at t+1 and publishes at t+4; a tick before last_acc+4 is lost.
    bit known = 0;
    int cyc;
    int last_acc;
    int acc;
    int pend;
    int hist[$];
    int exp_fb, exp_v, exp_ovr;
    int obs_fb[$];
    int obs_cyc[$];

    always @(negedge clk) begin
        int sd, idx, dly, diff, stp, v;
        if (known) begin
            chk("feedback_out", int'(feedback_out), exp_fb);
            chk("fb_valid", int'(fb_valid), exp_v);
            chk("overrun", int'(overrun), exp_ovr);
            if (fb_valid) begin
                obs_fb.push_back(int'(feedback_out));
                obs_cyc.push_back(cyc);
            end
        end
        if (rst) begin
            known = 1;
            cyc = 0; last_acc = -100; acc = 0; pend = 0;
            hist.delete();
            exp_fb = 0; exp_v = 0; exp_ovr = 0;
        end else begin
            sd = int'(sample_div);
            exp_v = 0;
            if ((cyc % (sd + 1)) == sd) begin
                if (cyc >= last_acc + 4) last_acc = cyc;
                else exp_ovr = 1;
            end
            if (cyc == last_acc + 1) begin
                hist.push_back(int'(ctrl_in));
                idx = hist.size() - 1 - int'(dead_time);
                dly = (idx >= 0) ? hist[idx] : 0;
                diff = dly * 256 - acc;
                stp = diff >>> lag_shift;
                if (diff > 0 && stp == 0) stp = 1;
                pend = acc + stp;
            end
            if (cyc == last_acc + 3) begin
                acc = pend;
                v = acc / 256;
`ifdef PLANT_DISTURB_EN
                v = v + int'($signed(disturb));
                if (v < 0) v = 0;
                if (v > 255) v = 255;
`endif
                exp_fb = v;
                exp_v = 1;
            end
            cyc++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int sd, input int dt, input int k, input int c);
        step();
        rst = 1'b1;
        sample_div = 16'(sd);
        dead_time = 4'(dt);
        lag_shift = 3'(k);
        ctrl_in = 8'(c);
        step();
        step();
        rst = 1'b0;
        obs_fb.delete();
        obs_cyc.delete();
    endtask

    task automatic wait_n(input int n, input int budget);
        int b = 0;
        while (obs_fb.size() < n && b < budget) begin
            step();
            b++;
        end
        if (obs_fb.size() < n) chk("fb_valid_timeout", obs_fb.size(), n);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Step, no lag, no delay: first output 4 cycles after the tick at cycle 3.
        do_reset(3, 0, 0, 8'h80);
        chk("reset_fb", int'(feedback_out), 0);
        chk("reset_valid", int'(fb_valid), 0);
        chk("reset_overrun", int'(overrun), 0);
        wait_n(1, 40);
        if (obs_fb.size() >= 1) begin
            chk("step_value", obs_fb[0], 8'h80);
            chk("step_latency", obs_cyc[0], 3 + 4);
        end

        // Dead time of three samples.
        do_reset(3, 3, 0, 8'h80);
        wait_n(4, 80);
        if (obs_fb.size() >= 4) begin
            chk("dead_s0", obs_fb[0], 0);
            chk("dead_s1", obs_fb[1], 0);
            chk("dead_s2", obs_fb[2], 0);
            chk("dead_s3", obs_fb[3], 8'h80);
        end

        // First-order lag, k = 1: up to 0x80 then back down to 0.
        do_reset(3, 0, 1, 8'h80);
        wait_n(24, 400);
        if (obs_fb.size() >= 24) begin
            chk("lag_up0", obs_fb[0], 8'h40);
            chk("lag_up1", obs_fb[1], 8'h60);
            chk("lag_up2", obs_fb[2], 8'h70);
            chk("lag_up3", obs_fb[3], 8'h78);
            chk("lag_up4", obs_fb[4], 8'h7C);
            chk("lag_up_final", obs_fb[23], 8'h80);
        end
        ctrl_in = 8'h00;
        obs_fb.delete();
        obs_cyc.delete();
        wait_n(24, 400);
        if (obs_fb.size() >= 24) begin
            chk("lag_dn0", obs_fb[0], 8'h40);
            chk("lag_dn1", obs_fb[1], 8'h20);
            chk("lag_dn_final", obs_fb[23], 8'h00);
        end

        // Overrun: a period of 3 cycles loses every other tick.
        do_reset(2, 0, 0, 8'h11);
        step(); step(); step(); step();
        chk("ovr_before_second_tick", int'(overrun), 0);
        wait_n(3, 60);
        if (obs_fb.size() >= 3) begin
            chk("ovr_period_a", obs_cyc[1] - obs_cyc[0], 6);
            chk("ovr_period_b", obs_cyc[2] - obs_cyc[1], 6);
        end
        chk("ovr_sticky", int'(overrun), 1);
        rst = 1'b1;
        step();
        chk("ovr_cleared", int'(overrun), 0);

        // Overrun with the shortest period (model-checked).
        do_reset(1, 0, 0, 8'h22);
        wait_n(4, 60);

        // Reset during FILTER.
        do_reset(3, 0, 0, 8'h55);
        wait_n(1, 40);               // now in the cycle after the tick (CAPTURE)
        if (obs_fb.size() >= 1) chk("mid_first", obs_fb[0], 8'h55);
        step();                      // FILTER
        rst = 1'b1;
        step();
        chk("mid_valid", int'(fb_valid), 0);
        chk("mid_fb", int'(feedback_out), 0);
        chk("mid_ovr", int'(overrun), 0);
        rst = 1'b0;
        dead_time = 4'd15;
        ctrl_in = 8'h33;
        obs_fb.delete();
        obs_cyc.delete();
        wait_n(3, 60);
        if (obs_fb.size() >= 3) begin
            chk("mid_buf0", obs_fb[0], 0);
            chk("mid_buf1", obs_fb[1], 0);
            chk("mid_buf2", obs_fb[2], 0);
        end

`ifdef PLANT_DISTURB_EN
        disturb = 8'h20;
        do_reset(3, 0, 0, 8'hF0);
        wait_n(1, 40);
        if (obs_fb.size() >= 1) chk("sat_high", obs_fb[0], 8'hFF);
        disturb = 8'hE0;
        do_reset(3, 0, 0, 8'h10);
        wait_n(1, 40);
        if (obs_fb.size() >= 1) chk("sat_low", obs_fb[0], 8'h00);
        disturb = 8'h10;
        do_reset(3, 0, 0, 8'h50);
        wait_n(1, 40);
        if (obs_fb.size() >= 1) chk("dist_mid", obs_fb[0], 8'h60);
        disturb = 8'h00;
`endif

        // Randomized runs against the model.
        for (int r = 0; r < 6; r++) begin
            do_reset(int'($urandom_range(0, 6)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
            for (int c = 0; c < 300; c++) begin
                ctrl_in = 8'($urandom_range(0, 255));
`ifdef PLANT_DISTURB_EN
                disturb = 8'($urandom_range(0, 255));
`endif
                if ($urandom_range(0, 39) == 0) dead_time = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 39) == 0) lag_shift = 3'($urandom_range(0, 7));
                rst = ($urandom_range(0, 149) == 0);
                step();
            end
            rst = 1'b0;
        end

        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
